native_mem_arb: RTL and testbench

NATIVE_MEM_ARB -- requirements
Module: native_mem_arb

---
 rtl/native_mem_arb_if.sv | 22 ++
 rtl/native_mem_arb.sv | 170 +++++++++++++++++
 tb/tb_native_mem_arb.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/native_mem_arb_if.sv
// Native memory request bus: NPORTS packed request/response lanes.
interface native_mem_arb_if #(
    parameter int unsigned NPORTS = 2
);
    logic [NPORTS-1:0]    mem_valid;
    logic [NPORTS-1:0]    mem_ready;
    logic [32*NPORTS-1:0] mem_addr;
    logic [32*NPORTS-1:0] mem_wdata;
    logic [4*NPORTS-1:0]  mem_wstrb;
    logic [32*NPORTS-1:0] mem_rdata;
    logic [NPORTS-1:0]    mem_err;

    modport master (
        output mem_valid, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata, mem_err
    );

    modport slave (
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata, mem_err
    );
endinterface

// File: rtl/native_mem_arb.sv
// Round-robin arbiter in front of a single-ported word array; one transaction in flight.
module native_mem_arb #(
    parameter int unsigned NPORTS     = 2,
    parameter int unsigned SIZE_WORDS = 32768,
    parameter logic [31:0] BASE_ADDR  = 32'h0,
    parameter int unsigned LATENCY    = 0
) (
    input  logic            clk,
    input  logic            resetn,
    native_mem_arb_if.slave bus
);
    localparam int unsigned   AW        = (SIZE_WORDS > 1) ? $clog2(SIZE_WORDS) : 1;
    localparam int unsigned   PW        = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam logic [3:0]    LAT       = 4'(LATENCY);
    localparam logic [PW-1:0] LAST_PORT = PW'(NPORTS - 1);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e            state_q, state_d;
    logic [PW-1:0]     last_grant_q, last_grant_d;
    logic [PW-1:0]     grant_q, grant_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic [NPORTS-1:0] served_q;

    logic [31:0]       memory [SIZE_WORDS];
    logic [31:0]       rdata_q [NPORTS];

    logic [NPORTS-1:0] eligible;
    logic              found;
    logic [PW-1:0]     pick;
    int unsigned       cand;

    logic [31:0]       req_addr;
    logic [31:0]       req_off;
    logic [31:0]       req_word;
    logic              req_in_range;
    logic [AW-1:0]     req_idx;

    // The port answered last cycle still shows valid while its master reacts; mask it once.
    assign eligible = bus.mem_valid & ~served_q;

    // Round-robin search starting one past the last granted port.
    always_comb begin
        found = 1'b0;
        pick  = last_grant_q;
        cand  = 0;
        for (int i = 1; i <= int'(NPORTS); i++) begin
            cand = (int'(last_grant_q) + i) % NPORTS;
            if (!found && eligible[cand[PW-1:0]]) begin
                found = 1'b1;
                pick  = cand[PW-1:0];
            end
        end
    end

    // Address of the transaction being decided: live input while granting, captured afterwards.
    always_comb begin
        req_addr     = (state_q == StIdle) ? bus.mem_addr[32*pick +: 32] : addr_q;
        req_off      = req_addr - BASE_ADDR;
        req_word     = req_off >> 2;
        req_in_range = (req_addr >= BASE_ADDR) && (req_word < SIZE_WORDS);
        req_idx      = req_word[AW-1:0];
    end

    // Next-state logic: grant and capture in IDLE, count wait states, answer in RESP.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        case (state_q)
            StIdle: begin
                if (found) begin
                    grant_d      = pick;
                    last_grant_d = pick;
                    addr_d       = bus.mem_addr[32*pick +: 32];
                    wdata_d      = bus.mem_wdata[32*pick +: 32];
                    wstrb_d      = bus.mem_wstrb[4*pick +: 4];
                    cnt_d        = LAT;
                    state_d      = (LAT == 4'd0) ? StResp : StWait;
                end
            end
            StWait: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Control state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= StIdle;
            last_grant_q <= LAST_PORT;
            grant_q      <= '0;
            cnt_q        <= 4'd0;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            wstrb_q      <= 4'h0;
            served_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            served_q     <= '0;
            if (state_q == StResp) begin
                served_q[grant_q] <= 1'b1;
            end
        end
    end

    // Response data is read on entry to RESP, so it is the word before this write lands.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int p = 0; p < int'(NPORTS); p++) begin
                rdata_q[p] <= 32'h0;
            end
        end else if (state_d == StResp && state_q != StResp) begin
            rdata_q[grant_d] <= req_in_range ? memory[req_idx] : 32'h0;
        end
    end

    // Byte-lane write at the RESP edge; no reset so contents survive resetn.
    always_ff @(posedge clk) begin
        if (resetn && state_q == StResp && req_in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb_q[b]) begin
                    memory[req_idx][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

    // Ready and error pulse only for the granted port during RESP.
    always_comb begin
        bus.mem_ready = '0;
        bus.mem_err   = '0;
        if (state_q == StResp) begin
            bus.mem_ready[grant_q] = 1'b1;
            bus.mem_err[grant_q]   = !req_in_range;
        end
    end

    // Per-port read data held until that port's next response.
    always_comb begin
        bus.mem_rdata = '0;
        for (int p = 0; p < int'(NPORTS); p++) begin
            bus.mem_rdata[32*p +: 32] = rdata_q[p];
        end
    end

endmodule

// File: tb/tb_native_mem_arb.sv
// Randomized bench for native_mem_arb: two instances (no wait states / three wait states).
module tb_native_mem_arb;
    localparam int unsigned NP    = 2;
    localparam int unsigned SIZE0 = 256;
    localparam logic [31:0] BASE0 = 32'h0;
    localparam int unsigned SIZE3 = 64;
    localparam logic [31:0] BASE3 = 32'h1000;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    native_mem_arb_if #(.NPORTS(NP)) bus0 ();
    native_mem_arb_if #(.NPORTS(NP)) bus3 ();

    native_mem_arb #(.NPORTS(NP), .SIZE_WORDS(SIZE0), .BASE_ADDR(BASE0), .LATENCY(0)) dut0 (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus0)
    );

    native_mem_arb #(.NPORTS(NP), .SIZE_WORDS(SIZE3), .BASE_ADDR(BASE3), .LATENCY(3)) dut3 (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus3)
    );

    int checks = 0;
    int errors = 0;

    // Reference memory contents and which words hold a known value.
    logic [31:0] mdl0 [SIZE0];
    bit          known0 [SIZE0];
    logic [31:0] mdl3 [SIZE3];
    bit          known3 [SIZE3];
    logic [31:0] last_rd [2][NP];
    bit          last_known [2][NP];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic drive(input int d, input int p, input logic v, input logic [31:0] a,
                         input logic [31:0] w, input logic [3:0] s);
        if (d == 1) begin
            bus3.mem_valid[p]          = v;
            bus3.mem_addr[32*p +: 32]  = a;
            bus3.mem_wdata[32*p +: 32] = w;
            bus3.mem_wstrb[4*p +: 4]   = s;
        end else begin
            bus0.mem_valid[p]          = v;
            bus0.mem_addr[32*p +: 32]  = a;
            bus0.mem_wdata[32*p +: 32] = w;
            bus0.mem_wstrb[4*p +: 4]   = s;
        end
    endtask

    function automatic logic get_ready(input int d, input int p);
        return (d == 1) ? bus3.mem_ready[p] : bus0.mem_ready[p];
    endfunction

    function automatic logic get_err(input int d, input int p);
        return (d == 1) ? bus3.mem_err[p] : bus0.mem_err[p];
    endfunction

    function automatic logic [31:0] get_rdata(input int d, input int p);
        return (d == 1) ? bus3.mem_rdata[32*p +: 32] : bus0.mem_rdata[32*p +: 32];
    endfunction

    // Word-addressed memory with byte strobes; returns the pre-write word or an error.
    task automatic model_access(input int d, input logic [31:0] a, input logic [31:0] w,
                                input logic [3:0] s, output logic [31:0] rd, output bit err,
                                output bit known);
        logic [31:0] base;
        int unsigned size;
        logic [31:0] wi;
        logic [31:0] word;
        base = (d == 1) ? BASE3 : BASE0;
        size = (d == 1) ? SIZE3 : SIZE0;
        wi   = (a - base) / 4;
        if (a < base || wi >= size) begin
            rd = 32'h0; err = 1'b1; known = 1'b1;
        end else begin
            word  = (d == 1) ? mdl3[wi] : mdl0[wi];
            known = (d == 1) ? known3[wi] : known0[wi];
            rd    = word;
            err   = 1'b0;
            for (int b = 0; b < 4; b++) begin
                if (s[b]) word[8*b +: 8] = w[8*b +: 8];
            end
            if (d == 1) begin
                mdl3[wi] = word;
                if (s == 4'hF) known3[wi] = 1'b1;
            end else begin
                mdl0[wi] = word;
                if (s == 4'hF) known0[wi] = 1'b1;
            end
        end
    endtask

    // One transaction on one port; disturb drops valid and scrambles inputs after the grant.
    task automatic txn(input int d, input int p, input logic [31:0] a, input logic [31:0] w,
                       input logic [3:0] s, input bit disturb, input string tag);
        logic [31:0] exp_rd, rd;
        bit          exp_err, known, seen;
        logic        er;
        int          n, lat, other;
        lat   = (d == 1) ? 3 : 0;
        other = 1 - p;
        model_access(d, a, w, s, exp_rd, exp_err, known);
        drive(d, p, 1'b1, a, w, s);
        n = 0; seen = 1'b0; rd = 32'h0; er = 1'b0;
        while (!seen && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (get_ready(d, p)) begin
                seen = 1'b1;
                rd   = get_rdata(d, p);
                er   = get_err(d, p);
            end else if (disturb && n == 1) begin
                drive(d, p, 1'b0, ~a, ~w, ~s);
            end
        end
        drive(d, p, 1'b0, a, w, s);
        check({tag, " latency"}, 32'(n), 32'(1 + lat));
        check({tag, " err"}, {31'b0, er}, {31'b0, exp_err});
        if (known) check({tag, " rdata"}, rd, exp_rd);
        last_rd[d][p]    = exp_rd;
        last_known[d][p] = known;
        @(posedge clk); #1;
        check({tag, " pulse width"}, {31'b0, get_ready(d, p)}, 32'h0);
        if (last_known[d][other]) check({tag, " other hold"}, get_rdata(d, other), last_rd[d][other]);
        check({tag, " rdata hold"}, {31'b0, (get_rdata(d, p) === rd) ? 1'b1 : 1'b0}, 32'h1);
        @(posedge clk); #1;
    endtask

    task automatic apply_reset();
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < int'(NP); p++) begin
                last_rd[d][p]    = 32'h0;
                last_known[d][p] = 1'b1;
            end
        end
    endtask

    initial begin
        logic [31:0] a, exp_rd;
        bit          exp_err, known;
        int          q[$];
        int          d, p, n;

        bus0.mem_valid = '0; bus0.mem_addr = '0; bus0.mem_wdata = '0; bus0.mem_wstrb = '0;
        bus3.mem_valid = '0; bus3.mem_addr = '0; bus3.mem_wdata = '0; bus3.mem_wstrb = '0;
        for (int i = 0; i < int'(SIZE0); i++) begin mdl0[i] = 32'h0; known0[i] = 1'b0; end
        for (int i = 0; i < int'(SIZE3); i++) begin mdl3[i] = 32'h0; known3[i] = 1'b0; end
        resetn = 1'b0;
        @(posedge clk); #1;
        apply_reset();

        // Reset state of both instances
        for (int i = 0; i < int'(NP); i++) begin
            check("reset ready0", {31'b0, get_ready(0, i)}, 32'h0);
            check("reset err0", {31'b0, get_err(0, i)}, 32'h0);
            check("reset rdata0", get_rdata(0, i), 32'h0);
            check("reset rdata3", get_rdata(1, i), 32'h0);
        end

        // Fill both arrays so every later read has a known expectation
        for (int i = 0; i < int'(SIZE0); i++)
            txn(0, i % 2, BASE0 + 32'(4 * i), $urandom, 4'hF, 1'b0, "init0");
        for (int i = 0; i < int'(SIZE3); i++)
            txn(1, i % 2, BASE3 + 32'(4 * i), $urandom, 4'hF, 1'b0, "init3");

        // Write then read back with no wait states
        txn(0, 0, 32'h100, 32'h12345678, 4'hF, 1'b0, "wr100");
        txn(0, 0, 32'h100, 32'h0, 4'h0, 1'b0, "rd100");

        // Three wait states: ready four cycles after valid
        txn(1, 0, BASE3 + 32'h10, 32'h0, 4'h0, 1'b0, "lat3 rd");

        // Partial strobes: response carries old word, array merges lanes 0 and 2
        txn(0, 1, 32'h40, 32'h11223344, 4'hF, 1'b0, "pre40");
        txn(0, 1, 32'h40, 32'hAABBCCDD, 4'b0101, 1'b0, "strb40");
        txn(0, 1, 32'h40, 32'h0, 4'h0, 1'b0, "rd40");

        // Out-of-range: error, zero data, and no aliasing into the array
        txn(0, 0, BASE0 + 32'(4 * SIZE0), 32'h0, 4'h0, 1'b0, "oor rd");
        txn(0, 1, BASE0 + 32'(4 * SIZE0), 32'hDEADBEEF, 4'hF, 1'b0, "oor wr");
        txn(0, 0, 32'h0, 32'h0, 4'h0, 1'b0, "alias rd");
        txn(1, 1, BASE3 - 32'h4, 32'hCAFEF00D, 4'hF, 1'b0, "below base");
        txn(1, 0, BASE3 + 32'(4 * SIZE3), 32'h0, 4'h0, 1'b0, "oor3 rd");

        // Both ports hold valid after reset: grants alternate starting at port 0
        apply_reset();
        drive(0, 0, 1'b1, 32'h10, 32'h0, 4'h0);
        drive(0, 1, 1'b1, 32'h20, 32'h0, 4'h0);
        n = 0;
        while (q.size() < 4 && n < 20) begin
            @(posedge clk); #1;
            n++;
            for (int i = 0; i < int'(NP); i++) begin
                if (get_ready(0, i)) begin
                    q.push_back(i);
                    model_access(0, (i == 0) ? 32'h10 : 32'h20, 32'h0, 4'h0, exp_rd, exp_err,
                                 known);
                    check("rr rdata", get_rdata(0, i), exp_rd);
                    last_rd[0][i] = exp_rd;
                end
            end
        end
        drive(0, 0, 1'b0, 32'h10, 32'h0, 4'h0);
        drive(0, 1, 1'b0, 32'h20, 32'h0, 4'h0);
        check("rr count", 32'(q.size()), 32'd4);
        for (int i = 0; i < q.size(); i++) check("rr order", 32'(q[i]), 32'(i % 2));
        repeat (2) @(posedge clk);
        #1;

        // Reset while a write is waiting: no response, word untouched, next request normal
        a = BASE3 + 32'h20;
        drive(1, 0, 1'b1, a, 32'h5A5A5A5A, 4'hF);
        @(posedge clk); #1;
        check("abort ready a", {31'b0, get_ready(1, 0)}, 32'h0);
        @(posedge clk); #1;
        check("abort ready b", {31'b0, get_ready(1, 0)}, 32'h0);
        drive(1, 0, 1'b0, a, 32'h5A5A5A5A, 4'hF);
        resetn = 1'b0;
        @(posedge clk); #1;
        check("abort ready c", {31'b0, get_ready(1, 0)}, 32'h0);
        resetn = 1'b1;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < int'(NP); j++) begin
                last_rd[i][j] = 32'h0; last_known[i][j] = 1'b1;
            end
        end
        @(posedge clk); #1;
        check("abort ready d", {31'b0, get_ready(1, 0)}, 32'h0);
        txn(1, 0, a, 32'h0, 4'h0, 1'b0, "after abort");

        // Random single-port traffic on both instances
        for (int it = 0; it < 200; it++) begin
            logic [31:0] base, w;
            int unsigned size;
            logic [3:0]  s;
            d    = $urandom_range(0, 1);
            p    = $urandom_range(0, NP - 1);
            base = (d == 1) ? BASE3 : BASE0;
            size = (d == 1) ? SIZE3 : SIZE0;
            if ($urandom_range(0, 7) != 0)
                a = base + 32'(4 * $urandom_range(0, size - 1)) + 32'($urandom_range(0, 3));
            else if (d == 1 && $urandom_range(0, 1) == 1)
                a = 32'($urandom_range(0, BASE3 - 1));
            else
                a = base + 32'(4 * size) + 32'(4 * $urandom_range(0, 255));
            w = $urandom;
            s = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(0, 15));
            txn(d, p, a, w, s, $urandom_range(0, 1) == 1, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
